// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared widths, FSM states and Sobel kernel coefficient tables
package sobel_pkg;

    localparam int PIX_W_DEF   = 8;
    localparam int ACC_W_DEF   = 12;
    localparam int SAT_MAX_DEF = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        MAG  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Weight = w, doubled when dbl is set; w is -1, 0 or +1.
    typedef struct packed {
        logic signed [1:0] w;
        logic              dbl;
    } coef_t;

    localparam coef_t C_ZR = 3'b000;
    localparam coef_t C_P1 = 3'b010;
    localparam coef_t C_P2 = 3'b011;
    localparam coef_t C_N1 = 3'b110;
    localparam coef_t C_N2 = 3'b111;

    function automatic coef_t kx(input logic [3:0] tap);
        case (tap)
            4'd0, 4'd6: kx = C_N1;
            4'd2, 4'd8: kx = C_P1;
            4'd3:       kx = C_N2;
            4'd5:       kx = C_P2;
            default:    kx = C_ZR;
        endcase
    endfunction

    function automatic coef_t ky(input logic [3:0] tap);
        case (tap)
            4'd0, 4'd2: ky = C_N1;
            4'd1:       ky = C_N2;
            4'd6, 4'd8: ky = C_P1;
            4'd7:       ky = C_P2;
            default:    ky = C_ZR;
        endcase
    endfunction

endpackage

// File: rtl/sobel_mag.sv
// rtl/sobel_mag.sv - combinational |gx|+|gy| with saturation to SAT_MAX
module sobel_mag
    import sobel_pkg::*;
#(
    parameter int PIX_W   = PIX_W_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int SAT_MAX = SAT_MAX_DEF
) (
    input  logic signed [ACC_W-1:0] gx,
    input  logic signed [ACC_W-1:0] gy,
    output logic        [PIX_W-1:0] mag
);

    logic [ACC_W-1:0] abs_x;
    logic [ACC_W-1:0] abs_y;
    logic [ACC_W-1:0] sum;

    always_comb begin
        abs_x = gx[ACC_W-1] ? ACC_W'(-gx) : ACC_W'(gx);
        abs_y = gy[ACC_W-1] ? ACC_W'(-gy) : ACC_W'(gy);
        sum   = abs_x + abs_y;
        mag   = (sum > ACC_W'(SAT_MAX)) ? PIX_W'(SAT_MAX) : sum[PIX_W-1:0];
    end

endmodule

// File: rtl/sobel_conv.sv
// rtl/sobel_conv.sv - sequential one-tap-per-cycle Sobel convolution responder
module sobel_conv
    import sobel_pkg::*;
#(
    parameter int PIX_W   = PIX_W_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int SAT_MAX = SAT_MAX_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rst_conv,
    input  logic [3*PIX_W-1:0] row1,
    input  logic [3*PIX_W-1:0] row2,
    input  logic [3*PIX_W-1:0] row3,
    output logic [PIX_W-1:0]   conv_result,
    output logic               conv_ready
);

    state_t                  state;
    state_t                  next_state;
    logic [3:0]              tap;
    logic [PIX_W-1:0]        p [0:8];
    logic signed [ACC_W-1:0] gx;
    logic signed [ACC_W-1:0] gy;
    logic [ACC_W-1:0]        pix_ext;
    logic signed [ACC_W-1:0] term_x;
    logic signed [ACC_W-1:0] term_y;
    logic [PIX_W-1:0]        mag;

    // Shift-and-add weighting keeps the datapath multiplier-free.
    function automatic logic signed [ACC_W-1:0] weigh(input coef_t c, input logic [ACC_W-1:0] v);
        logic [ACC_W-1:0] s;
        s = c.dbl ? {v[ACC_W-2:0], 1'b0} : v;
        case (c.w)
            2'sb01:  weigh = $signed(s);
            2'sb11:  weigh = -$signed(s);
            default: weigh = '0;
        endcase
    endfunction

    always_comb begin
        pix_ext = {{(ACC_W-PIX_W){1'b0}}, p[(tap <= 4'd8) ? tap : 4'd0]};
        term_x  = weigh(kx(tap), pix_ext);
        term_y  = weigh(ky(tap), pix_ext);
    end

    sobel_mag #(.PIX_W(PIX_W), .ACC_W(ACC_W), .SAT_MAX(SAT_MAX)) u_mag (
        .gx  (gx),
        .gy  (gy),
        .mag (mag)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (!rst_conv) next_state = ACC;
            ACC:  if (rst_conv) next_state = IDLE;
                  else if (tap == 4'd8) next_state = MAG;
            MAG:  next_state = rst_conv ? IDLE : DONE;
            DONE: if (rst_conv) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tap         <= '0;
            gx          <= '0;
            gy          <= '0;
            conv_result <= '0;
            conv_ready  <= 1'b0;
            for (int i = 0; i < 9; i++) p[i] <= '0;
        end else begin
            case (state)
                IDLE: if (!rst_conv) begin
                    for (int i = 0; i < 3; i++) begin
                        p[i]   <= row1[(2-i)*PIX_W +: PIX_W];
                        p[i+3] <= row2[(2-i)*PIX_W +: PIX_W];
                        p[i+6] <= row3[(2-i)*PIX_W +: PIX_W];
                    end
                    gx  <= '0;
                    gy  <= '0;
                    tap <= '0;
                end
                ACC, MAG: if (rst_conv) begin
                    gx  <= '0;
                    gy  <= '0;
                    tap <= '0;
                end else if (state == ACC) begin
                    gx  <= gx + term_x;
                    gy  <= gy + term_y;
                    tap <= tap + 4'd1;
                end else begin
                    conv_result <= mag;
                    conv_ready  <= 1'b1;
                end
                DONE: if (rst_conv) conv_ready <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sobel_conv.sv
// tb/tb_sobel_conv.sv - directed and random scoreboard checks for sobel_conv
module tb_sobel_conv;

    logic        clk = 1'b0;
    logic        rst;
    logic        rst_conv;
    logic [23:0] row1, row2, row3;
    logic [7:0]  conv_result;
    logic        conv_ready;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  e;
    int          cyc;
    bit          seen;

    always #5 clk = ~clk;

    sobel_conv dut (
        .clk         (clk),
        .rst         (rst),
        .rst_conv    (rst_conv),
        .row1        (row1),
        .row2        (row2),
        .row3        (row3),
        .conv_result (conv_result),
        .conv_ready  (conv_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] model(input logic [23:0] r1, input logic [23:0] r2, input logic [23:0] r3);
        int kxm[9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
        int kym[9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};
        logic [71:0] all;
        int gxm, gym, s;
        all = {r1, r2, r3};
        gxm = 0;
        gym = 0;
        for (int i = 0; i < 9; i++) begin
            gxm += kxm[i] * int'(all[71-8*i -: 8]);
            gym += kym[i] * int'(all[71-8*i -: 8]);
        end
        s = (gxm < 0 ? -gxm : gxm) + (gym < 0 ? -gym : gym);
        return (s > 255) ? 8'd255 : 8'(s);
    endfunction

    task automatic wait_ready(output int n);
        n = 0;
        while (n < 20) begin
            @(posedge clk); #1;
            n++;
            if (conv_ready) break;
        end
    endtask

    task automatic run_window(input logic [23:0] r1, input logic [23:0] r2, input logic [23:0] r3,
                              input logic [7:0] expv, input bit scramble, input string tag);
        int n;
        logic [7:0] want;
        exp_q.push_back(expv);
        @(negedge clk);
        row1 = r1; row2 = r2; row3 = r3;
        rst_conv = 1'b0;
        n = 0;
        while (n < 20) begin
            @(posedge clk); #1;
            n++;
            if (conv_ready) break;
            if (scramble && n == 2) begin
                row1 = 24'($urandom); row2 = 24'($urandom); row3 = 24'($urandom);
            end
        end
        check({tag, " latency"}, n, 11);
        want = exp_q.pop_front();
        check({tag, " result"}, conv_result, want);
        @(posedge clk); #1;
        check({tag, " hold ready"}, conv_ready, 1);
        check({tag, " hold result"}, conv_result, want);
        rst_conv = 1'b1;
        @(posedge clk); #1;
        check({tag, " ready drop"}, conv_ready, 0);
        check({tag, " result kept"}, conv_result, want);
    endtask

    initial begin
        rst = 1'b1; rst_conv = 1'b1;
        row1 = '0; row2 = '0; row3 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset ready", conv_ready, 0);
        check("reset result", conv_result, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle ready", conv_ready, 0);

        run_window(24'h0, 24'h0, 24'h0, 8'd0, 1'b0, "zeros");
        run_window(24'h0000FF, 24'h0000FF, 24'h0000FF, 8'd255, 1'b0, "sat");
        run_window({8'd10, 8'd10, 8'd20}, {8'd10, 8'd10, 8'd20}, {8'd10, 8'd10, 8'd20}, 8'd40, 1'b0, "gx_pos");
        run_window({8'd20, 8'd10, 8'd10}, {8'd20, 8'd10, 8'd10}, {8'd20, 8'd10, 8'd10}, 8'd40, 1'b0, "gx_neg");
        run_window(24'h0, 24'h0, {8'd5, 8'd5, 8'd5}, 8'd20, 1'b1, "gy_scramble");
        run_window({8'd10, 8'd10, 8'd20}, {8'd10, 8'd10, 8'd20}, {8'd10, 8'd10, 8'd20}, 8'd40, 1'b0, "pre_abort");

        // Abort at edge 5 of a run that would otherwise saturate.
        @(negedge clk);
        row1 = 24'h0000FF; row2 = 24'h0000FF; row3 = 24'h0000FF;
        rst_conv = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_conv = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (conv_ready) seen = 1'b1;
        end
        check("abort ready", seen, 0);
        check("abort result kept", conv_result, 40);
        run_window({8'd10, 8'd10, 8'd20}, {8'd10, 8'd10, 8'd20}, {8'd10, 8'd10, 8'd20}, 8'd40, 1'b0, "rerun");

        for (int k = 0; k < 3; k++) begin
            logic [23:0] a, b, c;
            a = 24'($urandom); b = 24'($urandom); c = 24'($urandom);
            run_window(a, b, c, model(a, b, c), 1'b0, "random");
        end
        run_window({8'd10, 8'd10, 8'd20}, {8'd10, 8'd10, 8'd20}, {8'd10, 8'd10, 8'd20}, 8'd40, 1'b0, "pre_rst");

        // rst during ACC
        @(negedge clk);
        row1 = 24'h0000FF; row2 = 24'h0000FF; row3 = 24'h0000FF;
        rst_conv = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check("rst acc ready", conv_ready, 0);
        check("rst acc result", conv_result, 0);
        rst = 1'b0; rst_conv = 1'b1;
        @(posedge clk); #1;

        // rst together with rst_conv while in DONE
        @(negedge clk);
        row1 = {8'd10, 8'd10, 8'd20}; row2 = row1; row3 = row1;
        rst_conv = 1'b0;
        wait_ready(cyc);
        check("done reach", cyc, 11);
        check("done result", conv_result, 40);
        rst = 1'b1; rst_conv = 1'b1;
        @(posedge clk); #1;
        check("rst done ready", conv_ready, 0);
        check("rst done result", conv_result, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        run_window(24'h0000FF, 24'h0000FF, 24'h0000FF, 8'd255, 1'b0, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
